uart_tx_core: RTL and testbench

Parametrised UART transmitter and successor to the fixed 8-N-1 transmitter. It runs on the system clock with an internal baud divider instead of a baud-rate clock. Data width, parity mode and stop-bit count are parameters, and a small input FIFO with a valid/ready handshake supports back-to-back frames. It sits between the command/response logic and the board TX pin.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_fifo.sv | 52 +++++
 rtl/uart_tx_core.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_core.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and the parity helper.
// uart_tx_core and the future receiver both use this package.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // Zero-extended data does not change the XOR, so one width covers 5..9 bits.
    function automatic logic parity_bit(input logic [8:0] data, input int unsigned mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO feeding the transmitter; pointers carry one extra wrap bit
// so full and empty stay distinct. rdata is the head word whenever non-empty.
module uart_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en, rd_en;

    assign level = wr_q - rd_q;
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (wr_q == rd_q);
    assign rdata = mem_q[rd_q[AW-1:0]];

    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    always_comb begin
        wr_d = wr_q + (AW+1)'(wr_en);
        rd_d = rd_q + (AW+1)'(rd_en);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_tx_core.sv
// Parametrised UART transmitter: FIFO-buffered words are framed as
// start / data (LSB first) / optional parity / stop bits at CLK_DIV clocks per bit.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned CLK_DIV    = 434,
    parameter int unsigned PARITY     = PAR_NONE,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 bit_end;

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && !fifo_full;
    assign bit_end   = (cnt_q == CNT_LAST);

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (in_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Next state; a queued word is loaded from IDLE or on the final stop cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        par_d    = par_q;
        fifo_pop = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    par_d    = parity_bit(9'(fifo_rdata), PARITY);
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bit_end) begin
                    cnt_d = '0;
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == STOP_LAST) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            shift_d  = fifo_rdata;
                            par_d    = parity_bit(9'(fifo_rdata), PARITY);
                            state_d  = ST_START;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Line level follows the current state one cycle later, keeping outputs registered.
    always_comb begin
        busy_d = (state_q != ST_IDLE);
        case (state_q)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_q[0];
            ST_PARITY: tx_d = par_q;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: four configurations (8N1, 8E1, 8O1, 7O2) at CLK_DIV=4.
module tb_uart_tx_core;
    import uart_pkg::*;

    logic clk;
    logic rst_n;
    logic [3:0]       in_valid_v, in_ready_v, tx_v, busy_v, done_v;
    logic [3:0][7:0]  in_data_v;
    logic [3:0][2:0]  lvl_v;

    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] rx_q[$];

    typedef struct {
        int          u;
        logic [7:0]  data;
        logic [10:0] bits;
        int          nbits;
    } vec_t;
    vec_t vecs[9];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_core #(.DATA_BITS(8), .CLK_DIV(4), .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_v[0]), .in_valid(in_valid_v[0]),
        .in_ready(in_ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]), .fifo_level(lvl_v[0]));
    uart_tx_core #(.DATA_BITS(8), .CLK_DIV(4), .PARITY(PAR_EVEN), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_v[1]), .in_valid(in_valid_v[1]),
        .in_ready(in_ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]), .fifo_level(lvl_v[1]));
    uart_tx_core #(.DATA_BITS(8), .CLK_DIV(4), .PARITY(PAR_ODD), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_v[2]), .in_valid(in_valid_v[2]),
        .in_ready(in_ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]), .fifo_level(lvl_v[2]));
    uart_tx_core #(.DATA_BITS(7), .CLK_DIV(4), .PARITY(PAR_ODD), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7o2 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_v[3][6:0]), .in_valid(in_valid_v[3]),
        .in_ready(in_ready_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .done(done_v[3]), .fifo_level(lvl_v[3]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_neg(input int n, inout logic ab);
        repeat (n) begin
            @(negedge clk);
            if (!rst_n) ab = 1'b1;
        end
    endtask

    // Receiver model for the 8N1 instance: samples mid-bit and queues decoded bytes.
    initial begin : mon
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx_v[0] === 1'b0) begin
                logic       ab;
                logic [7:0] b;
                logic       st;
                ab = 1'b0;
                wait_neg(2, ab);
                for (int i = 0; i < 8; i++) begin
                    wait_neg(4, ab);
                    b[i] = tx_v[0];
                end
                wait_neg(4, ab);
                st = tx_v[0];
                wait_neg(1, ab);
                if (!ab) begin
                    check("mon_stop_bit", 32'(st), 32'd1);
                    rx_q.push_back(b);
                end
            end
        end
    end

    task automatic run_frame(input vec_t v, input int n);
        string tag;
        int    bad_tx, done_cnt, done_at, busy_cnt;
        tag = $sformatf("vec%0d", n);
        @(negedge clk);
        in_data_v[v.u]  = v.data;
        in_valid_v[v.u] = 1'b1;
        @(posedge clk);
        #1 in_valid_v[v.u] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check({tag, "_pre_tx"},   32'(tx_v[v.u]),   32'd1);
        check({tag, "_pre_busy"}, 32'(busy_v[v.u]), 32'd0);
        bad_tx = 0; done_cnt = 0; done_at = -1; busy_cnt = 0;
        for (int k = 0; k < v.nbits * 4; k++) begin
            @(negedge clk);
            if (tx_v[v.u] !== v.bits[k / 4]) bad_tx++;
            if (busy_v[v.u] === 1'b1) busy_cnt++;
            if (done_v[v.u] === 1'b1) begin
                done_cnt++;
                done_at = k;
            end
        end
        check({tag, "_tx_bad_cycles"}, 32'(bad_tx), 32'd0);
        check({tag, "_busy_cycles"},   32'(busy_cnt), 32'(v.nbits * 4));
        check({tag, "_done_count"},    32'(done_cnt), 32'd1);
        check({tag, "_done_cycle"},    32'(done_at),  32'(v.nbits * 4 - 1));
        @(negedge clk);
        check({tag, "_post_busy"}, 32'(busy_v[v.u]), 32'd0);
        check({tag, "_post_tx"},   32'(tx_v[v.u]),   32'd1);
    endtask

    initial begin : main
        int   dn, busy_cnt, pushed, bad_rdy, max_lvl, g, low_cnt, busy_after;
        int   dt[3];
        logic acc;

        // frame bits: [0]=start, data LSB first, optional parity, stop(s)
        vecs[0] = '{0, 8'hA5, 11'b00_1101001010, 10};
        vecs[1] = '{0, 8'h00, 11'b00_1000000000, 10};
        vecs[2] = '{0, 8'hFF, 11'b00_1111111110, 10};
        vecs[3] = '{0, 8'h3C, 11'b00_1001111000, 10};
        vecs[4] = '{1, 8'hA5, 11'b10101001010,   11};
        vecs[5] = '{1, 8'h01, 11'b11000000010,   11};
        vecs[6] = '{2, 8'hA5, 11'b11101001010,   11};
        vecs[7] = '{3, 8'h7F, 11'b11011111110,   11};
        vecs[8] = '{3, 8'h05, 11'b11100001010,   11};

        in_valid_v = '0;
        in_data_v  = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_tx",       32'(tx_v[0]),       32'd1);
        check("rst_busy",     32'(busy_v[0]),     32'd0);
        check("rst_done",     32'(done_v[0]),     32'd0);
        check("rst_in_ready", 32'(in_ready_v[0]), 32'd1);
        check("rst_level",    32'(lvl_v[0]),      32'd0);
        check("rst_tx_7o2",   32'(tx_v[3]),       32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_tx_after_release", 32'(tx_v), 32'hF);

        for (int i = 0; i < 9; i++) run_frame(vecs[i], i);

        // Back-to-back: three words on consecutive cycles, no idle gap between frames.
        repeat (2) @(negedge clk);
        rx_q.delete();
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            in_valid_v[0] = 1'b1;
            in_data_v[0]  = 8'(i);
        end
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        dn = 0; busy_cnt = 0; dt = '{-1, -1, -1};
        for (int c = 0; c < 200; c++) begin
            if (c > 0) @(negedge clk);
            if (busy_v[0] === 1'b1) busy_cnt++;
            if (done_v[0] === 1'b1) begin
                if (dn < 3) dt[dn] = c;
                dn++;
            end
        end
        check("b2b_done_count", 32'(dn), 32'd3);
        check("b2b_first_done", 32'(dt[0]), 32'd39);
        check("b2b_gap_1",      32'(dt[1] - dt[0]), 32'd40);
        check("b2b_gap_2",      32'(dt[2] - dt[1]), 32'd40);
        check("b2b_busy",       32'(busy_cnt), 32'd120);
        check("b2b_rx_count",   32'(rx_q.size()), 32'd3);
        for (int i = 0; i < 3 && i < rx_q.size(); i++)
            check($sformatf("b2b_rx_%0d", i), 32'(rx_q[i]), 32'(i + 1));

        // FIFO full: stream 0x10..0x1F with in_valid held high.
        rx_q.delete();
        pushed = 0; bad_rdy = 0; max_lvl = 0; g = 0;
        @(negedge clk);
        in_valid_v[0] = 1'b1;
        in_data_v[0]  = 8'h10;
        while (pushed < 16 && g < 3000) begin
            acc = in_ready_v[0];
            if (in_ready_v[0] !== (lvl_v[0] != 3'd4)) bad_rdy++;
            if (int'(lvl_v[0]) > max_lvl) max_lvl = int'(lvl_v[0]);
            @(negedge clk);
            g++;
            if (acc) begin
                pushed++;
                in_data_v[0] = 8'h10 + 8'(pushed);
            end
            if (pushed == 16) in_valid_v[0] = 1'b0;
        end
        in_valid_v[0] = 1'b0;
        check("full_pushed",      32'(pushed),  32'd16);
        check("full_max_level",   32'(max_lvl), 32'd4);
        check("full_ready_level", 32'(bad_rdy), 32'd0);
        g = 0;
        while ((rx_q.size() < 16 || busy_v[0] !== 1'b0) && g < 2000) begin
            @(negedge clk);
            g++;
        end
        check("full_rx_count", 32'(rx_q.size()), 32'd16);
        for (int i = 0; i < 16 && i < rx_q.size(); i++)
            check($sformatf("full_rx_%0d", i), 32'(rx_q[i]), 32'(8'h10 + 8'(i)));

        // Reset in data bit 3 with two words still queued.
        rx_q.delete();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid_v[0] = 1'b1;
            in_data_v[0]  = 8'hA1 + 8'(i * 17);
        end
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        g = 0;
        while (tx_v[0] !== 1'b0 && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("rst_mid_start_seen", 32'(tx_v[0]), 32'd0);
        repeat (17) @(negedge clk);
        check("rst_mid_level_before", 32'(lvl_v[0]), 32'd2);
        check("rst_mid_busy_before",  32'(busy_v[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_tx",       32'(tx_v[0]),       32'd1);
        check("rst_mid_busy",     32'(busy_v[0]),     32'd0);
        check("rst_mid_level",    32'(lvl_v[0]),      32'd0);
        check("rst_mid_in_ready", 32'(in_ready_v[0]), 32'd1);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        low_cnt = 0; busy_after = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (tx_v[0] !== 1'b1) low_cnt++;
            if (busy_v[0] !== 1'b0) busy_after++;
        end
        check("rst_after_tx_low",  32'(low_cnt),     32'd0);
        check("rst_after_busy",    32'(busy_after),  32'd0);
        check("rst_after_rx",      32'(rx_q.size()), 32'd0);
        check("rst_after_level",   32'(lvl_v[0]),    32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
